// File: rtl/vga_scan_ctrl.sv
// Raster scan timing for the snake-game VGA path: issues the board RAM block
// address from the counters and re-times position/sync to line up with RAM data.
module vga_scan_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BLK_SHIFT = 4,
  parameter int BOARD_W   = 40
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_ce,
  output logic [10:0] blk_addr,
  output logic [9:0]  x_ptr,
  output logic [9:0]  y_ptr,
  output logic        valid,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        w_h_last, w_v_last;
  logic        w_vis, w_hs0, w_vs0, w_fs0;
  logic [9:0]  w_row, w_col;
  logic [10:0] w_row_base;
  logic [9:0]  r_x, r_y;
  logic        r_valid, r_hs, r_vs, r_fs;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_ce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Stage-0 decode, evaluated on the counters themselves
  assign w_vis = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs0 = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
  assign w_vs0 = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));
  assign w_fs0 = (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_row = r_v_cnt >> BLK_SHIFT;
  assign w_col = r_h_cnt >> BLK_SHIFT;

  // 40 = 32 + 8, so the row stride is two shifts and an add
  generate
    if (BOARD_W == 40) begin : g_row40
      assign w_row_base = (11'(w_row) << 5) + (11'(w_row) << 3);
    end else begin : g_rowmul
      assign w_row_base = 11'(w_row) * 11'(BOARD_W);
    end
  endgenerate

  assign blk_addr = w_vis ? (w_row_base + 11'(w_col)) : '0;

  // Stage 1: one pix_ce behind the counters, matching the RAM read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_fs    <= 1'b0;
    end else if (pix_ce) begin
      r_x     <= r_h_cnt;
      r_y     <= r_v_cnt;
      r_valid <= w_vis;
      r_hs    <= w_hs0;
      r_vs    <= w_vs0;
      r_fs    <= w_fs0;
    end
  end

  assign x_ptr       = r_x;
  assign y_ptr       = r_y;
  assign valid       = r_valid;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full-size raster plus a shrunken-timing
// instance so whole-frame behaviour fits in a short run.
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic pix_ce = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] a_blk, b_blk;
  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_val, a_hs, a_vs, a_fs;
  logic        b_val, b_hs, b_vs, b_fs;

  vga_scan_ctrl u_full (
    .clk(clk), .rstn(rstn), .pix_ce(pix_ce), .blk_addr(a_blk),
    .x_ptr(a_x), .y_ptr(a_y), .valid(a_val), .hs(a_hs), .vs(a_vs),
    .frame_start(a_fs)
  );

  // 16 x 10 total raster: hs low x 10..12, vs low y 7..8, frame = 160 ce
  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BLK_SHIFT(1), .BOARD_W(40)
  ) u_mini (
    .clk(clk), .rstn(rstn), .pix_ce(pix_ce), .blk_addr(b_blk),
    .x_ptr(b_x), .y_ptr(b_y), .valid(b_val), .hs(b_hs), .vs(b_vs),
    .frame_start(b_fs)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      pix_ce = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    pix_ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic seek_a(input int x, input int y, input int bound);
    int k;
    k = 0;
    while (!(a_x == 10'(x) && a_y == 10'(y)) && k < bound) begin
      step(1);
      k++;
    end
    chk($sformatf("seek_%0d_%0d", x, y), {31'd0, (a_x == 10'(x) && a_y == 10'(y))}, 32'd1);
  endtask

  initial begin
    int s, hs_lo, vs_lo, vs_first, hs_first, hs_last, val_lo, n_ce, bad, chg;
    logic [9:0] last_x;
    logic fs_first_ce;

    // reset state, both instances
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_valid", a_val, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_blk", a_blk, 0);
    chk("mini_rst_hs", b_hs, 1);
    rstn = 1'b1;

    // first pixel after release
    step(1);
    chk("first_x", a_x, 0);
    chk("first_y", a_y, 0);
    chk("first_valid", a_val, 1);
    chk("first_fs", a_fs, 1);
    chk("first_hs", a_hs, 1);
    chk("mini_first_fs", b_fs, 1);
    step(1);
    chk("second_x", a_x, 1);
    chk("second_fs", a_fs, 0);

    // whole frame on the mini raster
    s = 2; hs_lo = 0; vs_lo = 0; vs_first = -1;
    while (s < 400) begin
      step(1);
      s++;
      if (!b_hs) hs_lo++;
      if (!b_vs) begin
        vs_lo++;
        if (vs_first < 0) vs_first = int'(b_y);
      end
      if (b_x == 10'd6 && b_y == 10'd5) chk("mini_blk_last_vis", b_blk, 83);
      if (b_x == 10'd7 && b_y == 10'd0) chk("mini_blk_past_edge", b_blk, 0);
      if (b_fs) break;
    end
    chk("mini_frame_period", s - 1, 160);
    chk("mini_vs_lo_cnt", vs_lo, 32);
    chk("mini_vs_first_y", vs_first, 7);
    chk("mini_hs_lo_cnt", hs_lo, 30);
    chk("mini_fs_pos_x", b_x, 0);
    chk("mini_fs_pos_y", b_y, 0);

    // one full line on the 640x480 raster
    do_reset();
    step(1);
    hs_lo = 0; hs_first = -1; hs_last = -1; val_lo = 0;
    for (int k = 1; k <= 800; k++) begin
      step(1);
      if (!a_hs) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(a_x);
        hs_last = int'(a_x);
      end
      if (!a_val) val_lo++;
    end
    chk("line_hs_lo_cnt", hs_lo, 96);
    chk("line_hs_first_x", hs_first, 656);
    chk("line_hs_last_x", hs_last, 751);
    chk("line_valid_lo_cnt", val_lo, 160);
    chk("line_wrap_x", a_x, 0);
    chk("line_wrap_y", a_y, 1);

    // block address with a nonzero board row; counters lead outputs by one ce
    seek_a(299, 16, 20000);
    chk("blk_300_16", a_blk, 58);
    step(1);
    chk("aligned_x_300", a_x, 300);
    chk("aligned_y_16", a_y, 16);
    chk("aligned_valid", a_val, 1);
    seek_a(638, 31, 20000);
    chk("blk_639_31", a_blk, 79);
    step(1);
    chk("blk_640_31", a_blk, 0);
    chk("valid_x639", a_val, 1);
    step(1);
    chk("valid_x640", a_val, 0);

    // pix_ce low holds everything
    pix_ce = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_x", a_x, 640);
    chk("hold_y", a_y, 31);

    // 1-in-4 clock enable gives the same sequence, stable between enables
    do_reset();
    pix_ce = 1'b0;
    n_ce = 0; bad = 0; chg = 0; last_x = a_x; fs_first_ce = 1'b0;
    for (int c = 0; c < 160; c++) begin
      pix_ce = (c % 4 == 0);
      @(posedge clk);
      #1;
      if (c % 4 == 0) begin
        n_ce++;
        if (n_ce == 1) fs_first_ce = a_fs;
        if (a_x != 10'(n_ce - 1) || a_y != 10'd0 || a_val != 1'b1) bad++;
        last_x = a_x;
      end else if (a_x != last_x) begin
        chg++;
      end
    end
    chk("ce4_seq_errs", bad, 0);
    chk("ce4_changes_off_ce", chg, 0);
    chk("ce4_first_fs", fs_first_ce, 1);
    chk("ce4_final_x", a_x, 39);

    // asynchronous reset mid-line, inside the hsync pulse
    do_reset();
    seek_a(700, 1, 2000);
    chk("pre_rst_hs", a_hs, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_x", a_x, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_valid", a_val, 0);
    chk("mid_rst_hs", a_hs, 1);
    chk("mid_rst_fs", a_fs, 0);
    chk("mid_rst_blk", a_blk, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step(1);
    chk("resume_x", a_x, 0);
    chk("resume_y", a_y, 0);
    chk("resume_fs", a_fs, 1);
    step(1);
    chk("resume_x1", a_x, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
